// File: rtl/snoopy_motion_controller.sv
// Snoopy sprite motion: horizontal walk FSM with edge clamping, plus a
// jump/gravity vertical FSM. Positions advance only on frame ticks.
module snoopy_motion_controller #(
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 608,
    parameter int X_START  = 304,
    parameter int Y_GROUND = 400,
    parameter int SPEED    = 2,
    parameter int JUMP_V   = 8,
    parameter int GRAVITY  = 1
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_frame_tick,
    input  logic       i_input_left,
    input  logic       i_input_right,
    input  logic       i_input_jump,
    output logic [9:0] o_snoopy_x,
    output logic [9:0] o_snoopy_y,
    output logic       o_facing_left,
    output logic       o_airborne
);

    typedef enum logic [1:0] {H_IDLE, H_LEFT, H_RIGHT} hstate_t;
    typedef enum logic [1:0] {V_GROUND, V_RISE, V_FALL} vstate_t;

    localparam logic signed [11:0] LP_SPEED_W = 12'(SPEED);
    localparam logic signed [11:0] LP_XMIN_W  = 12'(X_MIN);
    localparam logic signed [11:0] LP_XMAX_W  = 12'(X_MAX);
    localparam logic [9:0]         LP_XMIN    = 10'(X_MIN);
    localparam logic [9:0]         LP_XMAX    = 10'(X_MAX);
    localparam logic [9:0]         LP_XSTART  = 10'(X_START);
    localparam logic [9:0]         LP_YGROUND = 10'(Y_GROUND);
    localparam logic [10:0]        LP_YGND_W  = 11'(Y_GROUND);
    localparam logic [4:0]         LP_JUMPV   = 5'(JUMP_V);
    localparam logic [5:0]         LP_JUMPV_W = 6'(JUMP_V);
    localparam logic [4:0]         LP_GRAV    = 5'(GRAVITY);
    localparam logic [5:0]         LP_GRAV_W  = 6'(GRAVITY);

    hstate_t     r_hState;
    vstate_t     r_vState;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [4:0]  r_vy;
    logic        r_facingLeft;
    logic        r_airborne;
    logic        r_jumpPrev;
    logic        r_jumpArmed;

    logic signed [11:0] w_xWide;
    logic signed [11:0] w_xDec;
    logic signed [11:0] w_xInc;
    logic [9:0]         w_xLeft;
    logic [9:0]         w_xRight;
    logic               w_jumpEdge;
    logic               w_riseClip;
    logic [4:0]         w_vyDec;
    logic [5:0]         w_vyInc;
    logic [4:0]         w_vyFall;
    logic [10:0]        w_yFall;
    logic               w_land;

    // Signed, widened clamp so a step past either wall never wraps around.
    assign w_xWide  = $signed({2'b00, r_x});
    assign w_xDec   = w_xWide - LP_SPEED_W;
    assign w_xInc   = w_xWide + LP_SPEED_W;
    assign w_xLeft  = (w_xDec < LP_XMIN_W) ? LP_XMIN  : w_xDec[9:0];
    assign w_xRight = (w_xInc > LP_XMAX_W) ? LP_XMAX  : w_xInc[9:0];

    // The armed flag blocks a jump level that was already high out of reset.
    assign w_jumpEdge = i_input_jump & ~r_jumpPrev & r_jumpArmed;

    assign w_riseClip = ({1'b0, r_y} < {6'b000000, r_vy});
    assign w_vyDec    = r_vy - LP_GRAV;
    assign w_vyInc    = {1'b0, r_vy} + LP_GRAV_W;
    assign w_vyFall   = (w_vyInc > LP_JUMPV_W) ? LP_JUMPV : w_vyInc[4:0];
    assign w_yFall    = {1'b0, r_y} + {6'b000000, w_vyFall};
    assign w_land     = (w_yFall >= LP_YGND_W);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_jumpPrev  <= 1'b0;
            r_jumpArmed <= 1'b0;
        end else begin
            r_jumpPrev  <= i_input_jump;
            r_jumpArmed <= r_jumpArmed | ~i_input_jump;
        end
    end

    // Position moves from the pre-edge state; the state itself follows inputs every clock.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hState     <= H_IDLE;
            r_x          <= LP_XSTART;
            r_facingLeft <= 1'b0;
        end else begin
            if (i_frame_tick) begin
                case (r_hState)
                    H_LEFT: begin
                        r_x <= w_xLeft;
                        if (w_xLeft != r_x) r_facingLeft <= 1'b1;
                    end
                    H_RIGHT: begin
                        r_x          <= w_xRight;
                        r_facingLeft <= 1'b0;
                    end
                    default: ;
                endcase
            end
            case (r_hState)
                H_IDLE: begin
                    if (i_input_left && !i_input_right)      r_hState <= H_LEFT;
                    else if (i_input_right && !i_input_left) r_hState <= H_RIGHT;
                end
                H_LEFT:  if (!i_input_left)  r_hState <= H_IDLE;
                H_RIGHT: if (!i_input_right) r_hState <= H_IDLE;
                default: r_hState <= H_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vState   <= V_GROUND;
            r_y        <= LP_YGROUND;
            r_vy       <= 5'd0;
            r_airborne <= 1'b0;
        end else begin
            case (r_vState)
                V_GROUND: begin
                    if (w_jumpEdge) begin
                        r_vState   <= V_RISE;
                        r_vy       <= LP_JUMPV;
                        r_airborne <= 1'b1;
                    end
                end
                V_RISE: begin
                    if (i_frame_tick) begin
                        if (w_riseClip) begin
                            r_y      <= 10'd0;
                            r_vy     <= 5'd0;
                            r_vState <= V_FALL;
                        end else begin
                            r_y  <= r_y - {5'b00000, r_vy};
                            r_vy <= w_vyDec;
                            if (w_vyDec == 5'd0) r_vState <= V_FALL;
                        end
                    end
                end
                V_FALL: begin
                    if (i_frame_tick) begin
                        if (w_land) begin
                            r_y        <= LP_YGROUND;
                            r_vy       <= 5'd0;
                            r_vState   <= V_GROUND;
                            r_airborne <= 1'b0;
                        end else begin
                            r_y  <= w_yFall[9:0];
                            r_vy <= w_vyFall;
                        end
                    end
                end
                default: begin
                    r_vState   <= V_GROUND;
                    r_airborne <= 1'b0;
                end
            endcase
        end
    end

    assign o_snoopy_x    = r_x;
    assign o_snoopy_y    = r_y;
    assign o_facing_left = r_facingLeft;
    assign o_airborne    = r_airborne;

endmodule

// File: tb/tb_snoopy_motion_controller.sv
// Scoreboarded bench for snoopy_motion_controller: a rule-level model queues
// expected positions on every frame tick, and a monitor checks them.
module tb_snoopy_motion_controller;

   logic clock = 1'b0;
   logic resetN;
   logic frameTick, inLeft, inRight, inJump;
   logic edgeLeft, edgeRight;
   logic [9:0] snoopyX, snoopyY, xL, yL, xR, yR;
   logic facingLeft, airborne, fL, aL, fR, aR;

   typedef struct {
      int x;
      int y;
      int f;
      int a;
   } expect_t;

   expect_t sbq[$];
   int tests = 0;
   int failed = 0;

   // Reference model state: direction -1/0/+1, vertical mode 0=ground 1=rise 2=fall
   int mX, mY, mVy, mMode, mDir, mFacing;
   bit mPrevJump;

   int ySeq[16] = '{392, 385, 379, 374, 370, 367, 365, 364,
                    365, 367, 370, 374, 379, 385, 392, 400};

   snoopy_motion_controller dut (
      .i_clock(clock), .i_reset_n(resetN), .i_frame_tick(frameTick),
      .i_input_left(inLeft), .i_input_right(inRight), .i_input_jump(inJump),
      .o_snoopy_x(snoopyX), .o_snoopy_y(snoopyY),
      .o_facing_left(facingLeft), .o_airborne(airborne)
   );

   snoopy_motion_controller #(.X_START(1)) dutLeftWall (
      .i_clock(clock), .i_reset_n(resetN), .i_frame_tick(frameTick),
      .i_input_left(edgeLeft), .i_input_right(1'b0), .i_input_jump(1'b0),
      .o_snoopy_x(xL), .o_snoopy_y(yL), .o_facing_left(fL), .o_airborne(aL)
   );

   snoopy_motion_controller #(.X_START(607)) dutRightWall (
      .i_clock(clock), .i_reset_n(resetN), .i_frame_tick(frameTick),
      .i_input_left(1'b0), .i_input_right(edgeRight), .i_input_jump(1'b0),
      .o_snoopy_x(xR), .o_snoopy_y(yR), .o_facing_left(fR), .o_airborne(aR)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic void modelReset();
      mX = 304; mY = 400; mVy = 0; mMode = 0; mDir = 0; mFacing = 0;
      mPrevJump = 1'b1;
   endfunction

   // One clock of the motion rules, all decisions taken from the pre-edge state
   function automatic void modelStep(input bit l, input bit r, input bit j, input bit t);
      bit jumpEdge;
      int nx;
      jumpEdge = j && !mPrevJump;
      mPrevJump = j;
      if (t && mDir == -1) begin
         nx = (mX - 2 < 0) ? 0 : mX - 2;
         if (nx != mX) mFacing = 1;
         mX = nx;
      end else if (t && mDir == 1) begin
         mX = (mX + 2 > 608) ? 608 : mX + 2;
         mFacing = 0;
      end
      if (mDir == 0) begin
         if (l && !r) mDir = -1;
         else if (r && !l) mDir = 1;
      end else if (mDir == -1 && !l) mDir = 0;
      else if (mDir == 1 && !r) mDir = 0;
      if (mMode == 0) begin
         if (jumpEdge) begin
            mMode = 1;
            mVy = 8;
         end
      end else if (t && mMode == 1) begin
         if (mY < mVy) begin
            mY = 0; mVy = 0; mMode = 2;
         end else begin
            mY = mY - mVy;
            mVy = mVy - 1;
            if (mVy == 0) mMode = 2;
         end
      end else if (t && mMode == 2) begin
         mVy = (mVy + 1 > 8) ? 8 : mVy + 1;
         if (mY + mVy >= 400) begin
            mY = 400; mVy = 0; mMode = 0;
         end else begin
            mY = mY + mVy;
         end
      end
   endfunction

   // Drives one clock's inputs at a falling edge and returns at the next falling edge
   task automatic applyStimulus(input bit l, input bit r, input bit j, input bit t);
      expect_t e;
      inLeft = l; inRight = r; inJump = j; frameTick = t;
      modelStep(l, r, j, t);
      if (t) begin
         e.x = mX; e.y = mY; e.f = mFacing; e.a = (mMode != 0) ? 1 : 0;
         sbq.push_back(e);
      end
      @(posedge clock);
      @(negedge clock);
      frameTick = 1'b0;
   endtask

   task automatic applyTicks(input int n, input bit l, input bit r, input bit j);
      for (int i = 0; i < n; i++) begin
         applyStimulus(l, r, j, 1'b0);
         applyStimulus(l, r, j, 1'b1);
      end
   endtask

   // Monitor: each frame tick edge presents a new position to be scored
   initial begin
      expect_t e;
      logic sampledTick, sampledRst;
      forever begin
         @(posedge clock);
         sampledTick = frameTick;
         sampledRst = resetN;
         if (sampledTick && sampledRst) begin
            #1;
            if (sbq.size() == 0) begin
               tests++;
               failed++;
               $display("[TB] FAIL scoreboard underflow: got tick output, expected none queued");
            end else begin
               e = sbq.pop_front();
               checkOutput("sb snoopy_x", int'(snoopyX), e.x);
               checkOutput("sb snoopy_y", int'(snoopyY), e.y);
               checkOutput("sb facing_left", int'(facingLeft), e.f);
               checkOutput("sb airborne", int'(airborne), e.a);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit [1:0] dirSel;
      resetN = 1'b0;
      frameTick = 0; inLeft = 0; inRight = 0; inJump = 0;
      edgeLeft = 0; edgeRight = 0;
      modelReset();
      repeat (2) @(negedge clock);
      checkOutput("reset snoopy_x", int'(snoopyX), 304);
      checkOutput("reset snoopy_y", int'(snoopyY), 400);
      checkOutput("reset facing_left", int'(facingLeft), 0);
      checkOutput("reset airborne", int'(airborne), 0);

      // Jump held high across reset release must not launch a jump
      inJump = 1'b1;
      resetN = 1'b1;
      applyStimulus(0, 0, 1, 0);
      applyTicks(3, 0, 0, 1);
      checkOutput("held jump airborne", int'(airborne), 0);
      applyStimulus(0, 0, 0, 0);

      applyTicks(5, 0, 1, 0);
      checkOutput("right5 snoopy_x", int'(snoopyX), 314);
      checkOutput("right5 facing_left", int'(facingLeft), 0);
      checkOutput("right5 snoopy_y", int'(snoopyY), 400);
      applyStimulus(0, 0, 0, 0);

      edgeLeft = 1'b1; edgeRight = 1'b1;
      applyTicks(1, 0, 0, 0);
      checkOutput("left wall tick1 x", int'(xL), 0);
      checkOutput("left wall facing", int'(fL), 1);
      checkOutput("right wall tick1 x", int'(xR), 608);
      applyTicks(1, 0, 0, 0);
      checkOutput("left wall tick2 x", int'(xL), 0);
      checkOutput("left wall facing clamped", int'(fL), 1);
      checkOutput("right wall tick2 x", int'(xR), 608);
      checkOutput("right wall facing", int'(fR), 0);
      checkOutput("wall unit snoopy_y", int'(yL), 400);
      edgeLeft = 1'b0; edgeRight = 1'b0;

      applyTicks(3, 1, 1, 0);
      checkOutput("both pressed x", int'(snoopyX), 314);
      applyTicks(3, 1, 0, 0);
      checkOutput("left after both x", int'(snoopyX), 308);
      checkOutput("left after both facing", int'(facingLeft), 1);
      applyStimulus(0, 0, 0, 0);

      applyStimulus(0, 0, 1, 0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 0, 0, 0);
         if (i == 3) begin
            applyStimulus(0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0);
         end
         applyStimulus(0, 0, 0, 1);
         checkOutput($sformatf("jump y tick%0d", i + 1), int'(snoopyY), ySeq[i]);
      end
      checkOutput("landed airborne", int'(airborne), 0);

      // Frame tick held low mid-jump: nothing may move
      applyStimulus(0, 0, 1, 0);
      applyTicks(5, 0, 0, 0);
      for (int i = 0; i < 20; i++)
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      checkOutput("hold snoopy_x", int'(snoopyX), mX);
      checkOutput("hold snoopy_y", int'(snoopyY), mY);
      applyStimulus(0, 0, 0, 0);
      applyTicks(14, 0, 0, 0);
      checkOutput("hold then land airborne", int'(airborne), 0);

      applyStimulus(0, 0, 1, 0);
      applyTicks(8, 0, 0, 0);
      checkOutput("apex snoopy_y", int'(snoopyY), 364);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("async reset snoopy_x", int'(snoopyX), 304);
      checkOutput("async reset snoopy_y", int'(snoopyY), 400);
      checkOutput("async reset facing_left", int'(facingLeft), 0);
      checkOutput("async reset airborne", int'(airborne), 0);
      modelReset();
      repeat (2) @(negedge clock);
      resetN = 1'b1;

      dirSel = 2'b00;
      for (int c = 0; c < 2500; c++) begin
         if ($urandom_range(0, 19) == 0) dirSel = 2'($urandom_range(0, 3));
         applyStimulus(dirSel[0], dirSel[1], $urandom_range(0, 29) == 0,
                       $urandom_range(0, 2) == 0);
      end

      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("scoreboard drained", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/snoopy_motion_controller.md
SNOOPY_MOTION_CONTROLLER -- requirements
Module: snoopy_motion_controller

Interface
REQ-001 Parameter X_MIN, default 0, leftmost legal snoopy_x.
REQ-002 Parameter X_MAX, default 608, rightmost legal snoopy_x (640 minus 32-pixel sprite).
REQ-003 Parameter X_START, default 304, snoopy_x after reset.
REQ-004 Parameter Y_GROUND, default 400, resting snoopy_y.
REQ-005 Parameter SPEED, default 2, horizontal pixels per frame tick.
REQ-006 Parameter JUMP_V, default 8, initial upward speed and maximum fall speed.
REQ-007 Parameter GRAVITY, default 1, speed change per frame tick.
REQ-008 clock  input  1  single clock; all state changes on its rising edge.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 frame_tick  input  1  one-cycle pulse, once per video frame; gates all position updates.
REQ-011 input_left  input  1  level, move left request.
REQ-012 input_right  input  1  level, move right request.
REQ-013 input_jump  input  1  level, jump request; only its rising edge acts.
REQ-014 snoopy_x  output  10  registered horizontal position.
REQ-015 snoopy_y  output  10  registered vertical position, 0 at top of screen.
REQ-016 facing_left  output  1  1 once the last horizontal motion was leftward.
REQ-017 airborne  output  1  1 whenever the vertical FSM is not in V_GROUND.

Function
REQ-018 The horizontal FSM SHALL have states H_IDLE, H_LEFT and H_RIGHT, evaluated every clock, independent of frame_tick.
- H_IDLE: left only -> H_LEFT; right only -> H_RIGHT; both or neither -> stay.
- H_LEFT: exits to H_IDLE when input_left = 0; stays when both are pressed.
- H_RIGHT: exits to H_IDLE when input_right = 0; stays when both are pressed.
REQ-019 On a frame_tick cycle, snoopy_x SHALL update from the current (pre-edge) horizontal state: H_LEFT -> max(X_MIN, x-SPEED); H_RIGHT -> min(X_MAX, x+SPEED); H_IDLE -> unchanged.
REQ-020 The clamp arithmetic SHALL use at least 11-bit signed width, so snoopy_x never wraps (x=1, SPEED=2 -> 0, not 1023).
REQ-021 facing_left SHALL set on any tick that moves x in H_LEFT, clear on any tick in H_RIGHT, and hold otherwise, including when the move is clamped.
REQ-022 A one-cycle rising-edge detector SHALL be applied to input_jump (previous sample registered).
REQ-023 The vertical FSM SHALL have states V_GROUND, V_RISE and V_FALL, with a 5-bit unsigned speed register vy.
REQ-024 V_GROUND with a jump edge SHALL go to V_RISE and load vy=JUMP_V on that clock, with no y change until the next frame_tick.
REQ-025 A jump edge in V_RISE or V_FALL SHALL be discarded and not queued.
REQ-026 On each frame_tick in V_RISE: y <= y-vy and vy <= vy-GRAVITY; when the new vy is 0, go to V_FALL.
- If y < vy, then y <= 0, vy <= 0 and the FSM goes to V_FALL.
REQ-027 On each frame_tick in V_FALL: vy' = min(JUMP_V, vy+GRAVITY), then y <= y+vy'.
- If y+vy' >= Y_GROUND, then y <= Y_GROUND, vy <= 0 and the FSM goes to V_GROUND.
REQ-028 Horizontal and vertical updates SHALL occur on the same frame_tick, independently.
REQ-029 With frame_tick held 0, snoopy_x, snoopy_y and vy SHALL hold indefinitely.

Reset
REQ-030 Asserting reset (low) at any time, including mid-jump, SHALL immediately force H_IDLE, V_GROUND, snoopy_x=X_START, snoopy_y=Y_GROUND, vy=0, facing_left=0, airborne=0 and the jump edge register to 0.
REQ-031 After reset deasserts, a jump level already high SHALL NOT trigger a jump; a fresh 0->1 edge is required.

Verification
REQ-032 The bench SHALL cover the following directed scenarios at default parameters:
- Right held for 5 ticks after reset -> snoopy_x=314, facing_left=0, snoopy_y=400.
- x=1, left held, 1 tick -> x=0; a further tick -> x=0; facing_left=1.
- x=607, right held, 2 ticks -> x=608 then 608.
- Both left and right pressed from H_IDLE for 3 ticks -> x unchanged; then release right -> x decreases by 2 per tick.
- Jump pulse then 16 ticks -> y sequence 392,385,379,374,370,367,365,364 (apex), then 365,367,370,374,379,385,392,400; airborne=0 after the 16th tick; a second jump pulse mid-air is ignored.
- reset asserted at apex -> outputs read 304/400 asynchronously, before the next clock edge.
